booking_arbiter: RTL and testbench

Shared seat-pool controller for the cinema ticket system. Arbitrates up to `N_TERM` booking terminals over one set of per-area seat counters using round-robin. Each request is validated against plug rules, availability and funds, and the counters are updated on success. A per-terminal req/ack handshake returns status and change to the winning terminal. Sits between the terminal front-ends (switch/button inputs) and the 7-segment display driver, which shows `seat_left` and `change`.

---
 rtl/booking_arbiter_if.sv | 25 ++
 rtl/booking_arbiter.sv | 160 ++++++++++++++++
 tb/tb_booking_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/booking_arbiter_if.sv
// Terminal-side bundle for the booking arbiter: per-terminal request operands
// and the shared result bus that feeds the 7-segment driver.
interface booking_arbiter_if #(
  parameter int N_TERM = 4
);
  logic [N_TERM-1:0]   req;
  logic [5*N_TERM-1:0] money;
  logic [2*N_TERM-1:0] area;
  logic [N_TERM-1:0]   plug;
  logic [N_TERM-1:0]   ack;
  logic [2:0]          status;
  logic [5:0]          change;
  logic [5:0]          seat_left;
  logic                busy;

  modport master (
    output req, money, area, plug,
    input  ack, status, change, seat_left, busy
  );

  modport slave (
    input  req, money, area, plug,
    output ack, status, change, seat_left, busy
  );
endinterface

// File: rtl/booking_arbiter.sv
// Round-robin seat-pool controller: serves one booking terminal per transaction,
// validates plug/availability/funds and updates the per-area seat counters.
module booking_arbiter #(
  parameter int         N_TERM     = 4,
  parameter logic [5:0] SEATS      = 6'd20,
  parameter logic [5:0] PLUG_SEATS = 6'd5,
  parameter logic [4:0] PRICE0     = 5'd5,
  parameter logic [4:0] PRICE1     = 5'd10,
  parameter logic [4:0] PRICE2     = 5'd15,
  parameter logic [4:0] PRICE3     = 5'd20
) (
  input  logic              clk,
  input  logic              rst,
  booking_arbiter_if.slave  bus
);

  localparam int IW = (N_TERM > 1) ? $clog2(N_TERM) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, ACK, RELEASE} state_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_SEAT_UNAVAIL = 3'd1,
    ST_INSUFF_FUND  = 3'd2,
    ST_INVALID_PLUG = 3'd3,
    ST_PLUG_UNAVAIL = 3'd4
  } status_e;

  state_e          state, state_nx;
  logic [IW-1:0]   rr_ptr, win, grant, ptr_nx;
  logic            grant_vld;
  logic [4:0]      money_l;
  logic [1:0]      area_l;
  logic            plug_l;
  logic [5:0]      std_cnt [4];
  logic [5:0]      plug_cnt [2];   // entry 0 = area 2, entry 1 = area 3
  status_e         status_q, eval_status;
  logic [5:0]      change_q, seat_left_q;
  logic [4:0]      price;
  logic            plug_pool;
  logic [5:0]      sel_cnt;

  // Round-robin pick: first requesting terminal at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_TERM; k++) begin
      idx = (int'(rr_ptr) + k) % N_TERM;
      if (!grant_vld && bus.req[idx]) begin
        grant     = IW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (area_l)
      2'd0:    price = PRICE0;
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      default: price = PRICE3;
    endcase
  end

  // Only areas 2 and 3 own a plug pool; an invalid plug request reports the
  // standard pool so seat_left always shows a real counter.
  assign plug_pool = plug_l & area_l[1];
  assign sel_cnt   = plug_pool ? plug_cnt[area_l[0]] : std_cnt[area_l];

  always_comb begin
    if (plug_l && !area_l[1])
      eval_status = ST_INVALID_PLUG;
    else if (sel_cnt == 6'd0)
      eval_status = plug_l ? ST_PLUG_UNAVAIL : ST_SEAT_UNAVAIL;
    else if (money_l < price)
      eval_status = ST_INSUFF_FUND;
    else
      eval_status = ST_OK;
  end

  assign ptr_nx = (win == IW'(N_TERM - 1)) ? '0 : win + 1'b1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_vld) state_nx = EVAL;
      EVAL:    state_nx = ACK;
      ACK:     state_nx = RELEASE;
      RELEASE: if (!bus.req[win]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.ack = '0;
    if (state == ACK) bus.ack[win] = 1'b1;
  end

  assign bus.status    = status_q;
  assign bus.change    = change_q;
  assign bus.seat_left = seat_left_q;
  assign bus.busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      win         <= '0;
      money_l     <= '0;
      area_l      <= '0;
      plug_l      <= 1'b0;
      status_q    <= ST_OK;
      change_q    <= '0;
      seat_left_q <= SEATS;
      // NOTE: the counter arrays are explicitly reloaded here; reset is the
      // only refill path, so they cannot be left as uninitialised storage.
      for (int a = 0; a < 4; a++) std_cnt[a] <= SEATS;
      plug_cnt[0] <= PLUG_SEATS;
      plug_cnt[1] <= PLUG_SEATS;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            win     <= grant;
            money_l <= bus.money[5*int'(grant) +: 5];
            area_l  <= bus.area[2*int'(grant) +: 2];
            plug_l  <= bus.plug[grant];
          end
        end
        EVAL: begin
          status_q <= eval_status;
          if (eval_status == ST_OK) begin
            change_q    <= {1'b0, money_l - price};
            seat_left_q <= sel_cnt - 6'd1;
            if (plug_pool) plug_cnt[area_l[0]] <= sel_cnt - 6'd1;
            else           std_cnt[area_l]     <= sel_cnt - 6'd1;
          end else begin
            change_q    <= {1'b0, money_l};
            seat_left_q <= sel_cnt;
          end
        end
        RELEASE: begin
          if (!bus.req[win]) rr_ptr <= ptr_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booking_arbiter.sv
// Directed bench for booking_arbiter: handshake latency, round-robin order,
// validation priorities, pool exhaustion and mid-transaction reset.
module tb_booking_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  booking_arbiter_if #(.N_TERM(N)) bus ();

  booking_arbiter #(.N_TERM(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int t, input int m, input int a, input logic p);
    bus.money[5*t +: 5] = 5'(m);
    bus.area[2*t +: 2]  = 2'(a);
    bus.plug[t]         = p;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait for any ack, then compare it with the expected one-hot.
  task automatic wait_ack(input string tag, input logic [31:0] exp_ack);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ack == '0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".ack"}, 32'(bus.ack), exp_ack);
  endtask

  task automatic release_wait(input int t, input string tag);
    int n;
    n = 0;
    bus.req[t] = 1'b0;
    @(negedge clk);
    check({tag, ".ack_pulse"}, 32'(bus.ack), 32'd0);
    while (bus.busy && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_txn(input string tag, input int t, input int m, input int a, input logic p,
                        input int exp_st, input int exp_ch, input int exp_sl, input bit chk_sl);
    set_op(t, m, a, p);
    bus.req[t] = 1'b1;
    wait_ack(tag, 32'(1) << t);
    check({tag, ".status"}, 32'(bus.status), 32'(exp_st));
    check({tag, ".change"}, 32'(bus.change), 32'(exp_ch));
    if (chk_sl) check({tag, ".seat_left"}, 32'(bus.seat_left), 32'(exp_sl));
    release_wait(t, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req   = '0;
    bus.money = '0;
    bus.area  = '0;
    bus.plug  = '0;
    do_reset();

    check("rst.ack",       32'(bus.ack),       32'd0);
    check("rst.status",    32'(bus.status),    32'd0);
    check("rst.change",    32'(bus.change),    32'd0);
    check("rst.seat_left", 32'(bus.seat_left), 32'd20);
    check("rst.busy",      32'(bus.busy),      32'd0);

    // Latency: ack exactly two edges after req is first sampled.
    set_op(0, 20, 1, 1'b0);
    bus.req[0] = 1'b1;
    @(negedge clk);
    check("lat.busy_eval", 32'(bus.busy), 32'd1);
    check("lat.ack_eval",  32'(bus.ack),  32'd0);
    @(negedge clk);
    check("lat.ack",       32'(bus.ack),       32'b0001);
    check("lat.status",    32'(bus.status),    32'd0);
    check("lat.change",    32'(bus.change),    32'd10);
    check("lat.seat_left", 32'(bus.seat_left), 32'd19);
    release_wait(0, "lat");

    // Round-robin from a fresh pointer.
    do_reset();
    set_op(0, 10, 0, 1'b0);
    set_op(2, 10, 0, 1'b0);
    bus.req = 4'b0101;
    wait_ack("rr1a", 32'b0001);
    check("rr1a.seat_left", 32'(bus.seat_left), 32'd19);
    check("rr1a.change",    32'(bus.change),    32'd5);
    bus.req[0] = 1'b0;
    wait_ack("rr1b", 32'b0100);
    check("rr1b.seat_left", 32'(bus.seat_left), 32'd18);
    release_wait(2, "rr1b");
    do_txn("rr_t0", 0, 10, 0, 1'b0, 0, 5, 17, 1'b1);
    bus.req = 4'b0101;
    wait_ack("rr2a", 32'b0100);
    check("rr2a.seat_left", 32'(bus.seat_left), 32'd16);
    bus.req[2] = 1'b0;
    wait_ack("rr2b", 32'b0001);
    check("rr2b.seat_left", 32'(bus.seat_left), 32'd15);
    release_wait(0, "rr2b");

    // Plug in area 0 is invalid; the following booking proves std_cnt[0] intact.
    do_txn("inv_plug", 1, 31, 0, 1'b1, 3, 31, 0, 1'b0);
    do_txn("after_inv", 1, 5, 0, 1'b0, 0, 0, 14, 1'b1);

    // Plug pool of area 3 drains to zero; standard pool of area 3 untouched.
    for (int i = 0; i < 5; i++)
      do_txn("plug3", 3, 25, 3, 1'b1, 0, 5, 4 - i, 1'b1);
    do_txn("plug3_empty", 3, 25, 3, 1'b1, 4, 25, 0, 1'b1);
    do_txn("std3", 3, 20, 3, 1'b0, 0, 0, 19, 1'b1);
    do_txn("plug2", 2, 31, 2, 1'b1, 0, 16, 4, 1'b1);

    // Funds boundary in area 2.
    do_txn("fund14", 2, 14, 2, 1'b0, 2, 14, 20, 1'b1);
    do_txn("fund15", 2, 15, 2, 1'b0, 0, 0, 19, 1'b1);

    // Reset while the arbiter is in EVAL.
    set_op(1, 20, 1, 1'b0);
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("rst_eval.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_eval.ack",       32'(bus.ack),       32'd0);
    check("rst_eval.status",    32'(bus.status),    32'd0);
    check("rst_eval.change",    32'(bus.change),    32'd0);
    check("rst_eval.seat_left", 32'(bus.seat_left), 32'd20);
    check("rst_eval.busy",      32'(bus.busy),      32'd0);
    bus.req = '0;
    @(negedge clk);
    check("rst_eval.ack_hold", 32'(bus.ack), 32'd0);
    rst = 1'b0;
    do_txn("reload_plug3", 3, 20, 3, 1'b1, 0, 0, 4, 1'b1);
    do_txn("reload_std0", 0, 5, 0, 1'b0, 0, 0, 19, 1'b1);

    // Drain standard area 1 completely, then one more is refused.
    for (int i = 0; i < 20; i++)
      do_txn("drain1", 1, 10, 1, 1'b0, 0, 0, 19 - i, 1'b1);
    do_txn("seat_unavail", 1, 10, 1, 1'b0, 1, 10, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
